// File: rtl/lfmr_timing_datapath.sv
// lfmr_timing_datapath
//   Timing/datapath primitives for the UART receiver, sharing one clock and
//   one synchronous active-high reset:
//     - reloadable down-counter with a one-clk terminal strobe (bit timer)
//     - one-hot demultiplexer (data-bit slot steering)
//     - small add/sub/logic/compare unit (bit-index arithmetic)
//   LATENCY adds that many output register stages to every path.
//
// Ports
//   clk              system clock, rising edge
//   rst              synchronous active-high reset
//   cnt_enable       counter advances only when high
//   cnt_reset_value  reload value R (CNT_WIDTH)
//   cnt_strobe       one-clk pulse on terminal count (1+LATENCY clks after)
//   dmx_sel          slot select
//   dmx_in           data to steer (DMX_WIDTH)
//   dmx_out          slot k at [k*DMX_WIDTH +: DMX_WIDTH]
//   m_i1, m_i2, m_i3 math operands (MATH_WIDTH)
//   m_sum, m_sub, m_and, m_or, m_xor   math results (MATH_WIDTH)
//   m_eq, m_neq      m_i1 == m_i3 and its complement
module lfmr_timing_datapath #(
   parameter int unsigned CNT_WIDTH   = 8,
   parameter int unsigned DMX_WIDTH   = 1,
   parameter int unsigned DMX_OUTPUTS = 8,
   parameter int unsigned MATH_WIDTH  = 4,
   parameter int unsigned LATENCY     = 0,
   localparam int unsigned SEL_WIDTH  = (DMX_OUTPUTS > 1) ? $clog2(DMX_OUTPUTS) : 1
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             cnt_enable,
   input  logic [CNT_WIDTH-1:0]             cnt_reset_value,
   output logic                             cnt_strobe,
   input  logic [SEL_WIDTH-1:0]             dmx_sel,
   input  logic [DMX_WIDTH-1:0]             dmx_in,
   output logic [DMX_WIDTH*DMX_OUTPUTS-1:0] dmx_out,
   input  logic [MATH_WIDTH-1:0]            m_i1,
   input  logic [MATH_WIDTH-1:0]            m_i2,
   input  logic [MATH_WIDTH-1:0]            m_i3,
   output logic [MATH_WIDTH-1:0]            m_sum,
   output logic [MATH_WIDTH-1:0]            m_sub,
   output logic [MATH_WIDTH-1:0]            m_and,
   output logic [MATH_WIDTH-1:0]            m_or,
   output logic [MATH_WIDTH-1:0]            m_xor,
   output logic                             m_eq,
   output logic                             m_neq
);

   localparam int unsigned DW = DMX_WIDTH * DMX_OUTPUTS;
   localparam int unsigned MW = MATH_WIDTH;
   localparam int unsigned PW = 1 + DW + 5 * MW + 2;

   // ---------------- counter ----------------
   logic [CNT_WIDTH-1:0] count;
   logic                 raw_strobe;

   always_ff @(posedge clk) begin
      if (rst) begin
         count      <= cnt_reset_value;
         raw_strobe <= 1'b0;
      end else if (cnt_enable) begin
         if (count == '0) begin
            count      <= cnt_reset_value;
            raw_strobe <= 1'b1;
         end else begin
            count      <= count - 1'b1;
            raw_strobe <= 1'b0;
         end
      end else begin
         raw_strobe <= 1'b0;
      end
   end

   // ---------------- demux ----------------
   logic [DW-1:0] dmx_comb;

   always_comb begin
      dmx_comb = '0;
      for (int unsigned k = 0; k < DMX_OUTPUTS; k++) begin
         if (32'(dmx_sel) == k) dmx_comb[k*DMX_WIDTH +: DMX_WIDTH] = dmx_in;
      end
   end

   // ---------------- math ----------------
   logic [MW-1:0] sum_c, sub_c, and_c, or_c, xor_c;
   logic          eq_c;

   always_comb begin
      sum_c = m_i1 + m_i2;
      sub_c = m_i1 - m_i2;
      and_c = m_i1 & m_i2;
      or_c  = m_i1 | m_i2;
      xor_c = m_i1 ^ m_i2;
      eq_c  = (m_i1 == m_i3);
   end

   // ---------------- shared output pipeline ----------------
   // All three paths ride one delay line so every output of a path (and the
   // paths relative to each other) stays aligned. raw_strobe is already a
   // register, so the counter path is 1+LATENCY and never combinational.
   logic [PW-1:0] pipe_in, pipe_out;

   assign pipe_in = {raw_strobe, dmx_comb, sum_c, sub_c, and_c, or_c, xor_c, eq_c, ~eq_c};

   generate
      if (LATENCY == 0) begin : g_nolat
         assign pipe_out = pipe_in;
      end else begin : g_lat
         logic [PW-1:0] stage [LATENCY];

         always_ff @(posedge clk) begin
            if (rst) begin
               for (int unsigned i = 0; i < LATENCY; i++) stage[i] <= '0;
            end else begin
               stage[0] <= pipe_in;
               for (int unsigned i = 1; i < LATENCY; i++) stage[i] <= stage[i-1];
            end
         end

         assign pipe_out = stage[LATENCY-1];
      end
   endgenerate

   assign {cnt_strobe, dmx_out, m_sum, m_sub, m_and, m_or, m_xor, m_eq, m_neq} = pipe_out;

endmodule

// File: tb/tb_lfmr_timing_datapath.sv
module tb_lfmr_timing_datapath;

   logic       clk = 1'b0;
   logic       rst;
   logic       cnt_enable;
   logic [7:0] cnt_reset_value;
   logic [2:0] dmx_sel;
   logic       dmx_in;
   logic [3:0] m_i1, m_i2, m_i3;

   // index g = LATENCY of that instance (0, 1, 2)
   logic       strobe [3];
   logic [7:0] dout   [3];
   logic [3:0] sum    [3];
   logic [3:0] sub    [3];
   logic [3:0] andv   [3];
   logic [3:0] orv    [3];
   logic [3:0] xorv   [3];
   logic       eq     [3];
   logic       neq    [3];

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      lfmr_timing_datapath #(
         .CNT_WIDTH(8), .DMX_WIDTH(1), .DMX_OUTPUTS(8), .MATH_WIDTH(4), .LATENCY(g)
      ) u_dut (
         .clk(clk), .rst(rst), .cnt_enable(cnt_enable),
         .cnt_reset_value(cnt_reset_value), .cnt_strobe(strobe[g]),
         .dmx_sel(dmx_sel), .dmx_in(dmx_in), .dmx_out(dout[g]),
         .m_i1(m_i1), .m_i2(m_i2), .m_i3(m_i3),
         .m_sum(sum[g]), .m_sub(sub[g]), .m_and(andv[g]), .m_or(orv[g]),
         .m_xor(xorv[g]), .m_eq(eq[g]), .m_neq(neq[g])
      );
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1; cnt_enable = 1'b0; cnt_reset_value = 8'd3;
      dmx_sel = 3'd0; dmx_in = 1'b0; m_i1 = '0; m_i2 = '0; m_i3 = '0;
      #2;
      tick();

      // reset state
      for (int g = 0; g < 3; g++) chk($sformatf("rst_strobe_L%0d", g), 32'(strobe[g]), 0);
      chk("rst_dout_L1", 32'(dout[1]), 0);
      chk("rst_sum_L1", 32'(sum[1]), 0);
      chk("rst_eq_L2", 32'(eq[2]), 0);

      // R=3, enable held: L0 strobe at edges 4,8,12; L2 at 6,10,14
      rst = 1'b0; cnt_enable = 1'b1;
      for (int i = 1; i <= 14; i++) begin
         tick();
         chk($sformatf("per_L0_clk%0d", i), 32'(strobe[0]), 32'(i % 4 == 0));
         chk($sformatf("per_L2_clk%0d", i), 32'(strobe[2]), 32'(i > 2 && (i - 2) % 4 == 0));
      end

      // R=2, enable toggling 1,0,1,0: strobe at edges 5,11,17
      rst = 1'b1; cnt_reset_value = 8'd2; tick();
      rst = 1'b0;
      for (int i = 1; i <= 18; i++) begin
         cnt_enable = (i % 2 == 1);
         tick();
         chk($sformatf("tog_L0_clk%0d", i), 32'(strobe[0]), 32'(i % 6 == 5));
      end

      // reset mid-count: no strobe, count restarts from R
      cnt_enable = 1'b1; rst = 1'b1; tick();
      rst = 1'b0; tick(); tick();
      rst = 1'b1; tick();
      chk("midrst_strobe", 32'(strobe[0]), 0);
      rst = 1'b0; tick();
      chk("midrst_c1", 32'(strobe[0]), 0);
      tick();
      chk("midrst_c2", 32'(strobe[0]), 0);
      tick();
      chk("midrst_c3", 32'(strobe[0]), 1);

      // R changed mid-count only takes effect at reload
      cnt_reset_value = 8'd3; rst = 1'b1; tick();
      rst = 1'b0; tick();
      cnt_reset_value = 8'd0;
      tick(); tick();
      chk("rchg_c3", 32'(strobe[0]), 0);
      tick();
      chk("rchg_c4", 32'(strobe[0]), 1);
      tick();
      chk("rchg_c5", 32'(strobe[0]), 1);

      // R=0, LATENCY=2: strobe every enabled clk, first 3 clks after enabling
      cnt_enable = 1'b0; cnt_reset_value = 8'd0; rst = 1'b1; tick();
      rst = 1'b0; cnt_enable = 1'b1;
      for (int i = 1; i <= 6; i++) begin
         tick();
         chk($sformatf("r0_L2_clk%0d", i), 32'(strobe[2]), 32'(i >= 3));
         chk($sformatf("r0_L0_clk%0d", i), 32'(strobe[0]), 1);
      end
      cnt_enable = 1'b0;

      // demux, LATENCY=0
      dmx_in = 1'b1; dmx_sel = 3'd5; #1;
      chk("dmx_sel5", 32'(dout[0]), 32'h20);
      dmx_sel = 3'd0; #1;
      chk("dmx_sel0", 32'(dout[0]), 32'h01);
      dmx_sel = 3'd7; #1;
      chk("dmx_sel7", 32'(dout[0]), 32'h80);
      dmx_in = 1'b0; #1;
      chk("dmx_in0", 32'(dout[0]), 0);

      // math, LATENCY=0
      m_i1 = 4'd15; m_i2 = 4'd1; m_i3 = 4'd15; #1;
      chk("m_sum", 32'(sum[0]), 0);
      chk("m_sub", 32'(sub[0]), 14);
      chk("m_and", 32'(andv[0]), 1);
      chk("m_or", 32'(orv[0]), 15);
      chk("m_xor", 32'(xorv[0]), 14);
      chk("m_eq", 32'(eq[0]), 1);
      chk("m_neq", 32'(neq[0]), 0);
      m_i3 = 4'd3; #1;
      chk("m_eq_ne", 32'(eq[0]), 0);
      chk("m_neq_ne", 32'(neq[0]), 1);
      m_i1 = 4'd2; m_i2 = 4'd5; #1;
      chk("m_sub_wrap", 32'(sub[0]), 13);

      // LATENCY=1: vector appears one clk later and holds
      rst = 1'b1; tick();
      rst = 1'b0;
      m_i1 = 4'd15; m_i2 = 4'd1; m_i3 = 4'd15; dmx_in = 1'b1; dmx_sel = 3'd5; #1;
      chk("lat1_pre_or", 32'(orv[1]), 0);
      chk("lat1_pre_eq", 32'(eq[1]), 0);
      tick();
      chk("lat1_or", 32'(orv[1]), 15);
      chk("lat1_sub", 32'(sub[1]), 14);
      chk("lat1_eq", 32'(eq[1]), 1);
      chk("lat1_dmx", 32'(dout[1]), 32'h20);
      chk("lat2_not_yet", 32'(orv[2]), 0);
      tick();
      chk("lat1_hold_xor", 32'(xorv[1]), 14);
      chk("lat2_or", 32'(orv[2]), 15);

      // reset clears pipelined outputs; L0 math is unaffected
      rst = 1'b1; tick();
      chk("rst_lat1_or", 32'(orv[1]), 0);
      chk("rst_lat1_eq", 32'(eq[1]), 0);
      chk("rst_lat1_dmx", 32'(dout[1]), 0);
      chk("rst_lat2_dmx", 32'(dout[2]), 0);
      chk("rst_lat2_sum", 32'(sum[2]), 0);
      chk("rst_lat0_or", 32'(orv[0]), 15);
      rst = 1'b0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/lfmr_timing_datapath.md
Name: lfmr_timing_datapath

Overview:
- Bundles three clock-enabled datapath primitives under one clock and one reset:
  - a reloadable down-counter with a terminal strobe (baud/oversample timer);
  - a one-hot demultiplexer (bit-slot steering);
  - a small arithmetic/compare unit (bit-index increment and compare).
- Used by the UART receiver for its bit timing, data-bit capture and bit-count logic.
- A shared LATENCY parameter adds output register stages to every path so each can run at maximum clock rate.

Parameters:
- CNT_WIDTH, 8: counter and reset_value width.
- DMX_WIDTH, 1: width of each demux slot.
- DMX_OUTPUTS, 8: number of demux slots.
- MATH_WIDTH, 4: operand and result width of the math unit.
- LATENCY, 0: extra output register stages on each path (0 or more).

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- cnt_enable  in  1  counter advances only on cycles where this is high.
- cnt_reset_value  in  CNT_WIDTH  reload value R.
- cnt_strobe  out  1  one-clk pulse on counter terminal count.
- dmx_sel  in  max(1,clog2(DMX_OUTPUTS))  slot select.
- dmx_in  in  DMX_WIDTH  data to steer.
- dmx_out  out  DMX_WIDTH*DMX_OUTPUTS  slot k occupies bits [k*DMX_WIDTH +: DMX_WIDTH].
- m_i1, m_i2, m_i3  in  MATH_WIDTH each  math operands.
- m_sum, m_sub, m_and, m_or, m_xor  out  MATH_WIDTH each  results.
- m_eq, m_neq  out  1 each  compare results.

Behaviour:
- Reset (rst=1, synchronous, active-high):
  - counter register loads cnt_reset_value;
  - internal strobe register and all LATENCY pipeline registers clear to 0;
  - cnt_strobe=0;
  - registered dmx_out and math outputs read 0 once their pipelines flush (immediately on the next edge, since all stages are cleared).
  - While rst is held, no strobe is generated.
  - rst overrides cnt_enable.
- Counter, per clk with rst=0:
  - cnt_enable=1 and count==0: count <= cnt_reset_value; raw_strobe <= 1.
  - cnt_enable=1 and count!=0: count <= count-1; raw_strobe <= 0.
  - cnt_enable=0: count held; raw_strobe <= 0.
  - cnt_strobe = raw_strobe delayed by LATENCY further registers.
- Counter timing:
  - With enable held high, the first strobe is visible 1+LATENCY clks after the (R+1)-th enabled cycle following reset release.
  - Period is R+1 enabled cycles; pulse width is 1 clk.
  - R=0 gives a strobe on every enabled cycle.
  - R is sampled only during rst and at reload; changing it mid-count does not affect the current count.
- Demux:
  - Slot dmx_sel receives dmx_in; all other slots are 0.
  - dmx_sel >= DMX_OUTPUTS drives all slots to 0.
  - LATENCY=0: purely combinational.
  - LATENCY=L: result passes through L registers.
- Math unit:
  - m_sum = (m_i1+m_i2) mod 2^MATH_WIDTH.
  - m_sub = (m_i1-m_i2) mod 2^MATH_WIDTH.
  - m_and / m_or / m_xor are bitwise operations on m_i1, m_i2.
  - m_eq = (m_i1==m_i3); m_neq = !m_eq.
  - LATENCY=0: combinational, and rst has no effect on the math outputs.
  - LATENCY=L: all outputs are delayed L clks together, with pipeline registers cleared by rst.
- Alignment: all outputs of one path share the same latency, so results stay mutually aligned.
- No handshake: inputs are sampled every clk; outputs are valid LATENCY clks later (counter: 1+LATENCY).
- Structural requirements:
  - no combinational path from any input to cnt_strobe;
  - no latches;
  - no X on outputs after one rst cycle.

Test Plan:
- Counter period:
  - Setup: LATENCY=0, R=3, rst for 1 clk, then enable held high.
  - Required: cnt_strobe high on clk 4, 8, 12 after release, low otherwise; width 1.
- Counter enable and reset:
  - Setup: R=2; enable toggles 1,0,1,0,...
  - Required: strobe after 3 enabled cycles, period 6 clks.
  - Setup: assert rst mid-count.
  - Required: no strobe; count restarts from R.
- R=0 and LATENCY=2:
  - Required: strobe every enabled clk, first pulse 3 clks after the first enabled cycle.
- Demux:
  - Setup: DMX_OUTPUTS=8, LATENCY=0, dmx_in=1, sel=5.
  - Required: dmx_out=8'b0010_0000.
  - Setup: sel=0.
  - Required: dmx_out=8'b0000_0001.
  - Setup: dmx_in=0.
  - Required: dmx_out=0.
- Math:
  - Setup: MATH_WIDTH=4, i1=15, i2=1, i3=15.
  - Required: sum=0, sub=14, and=1, or=15, xor=14, eq=1, neq=0.
  - Setup: i3=3.
  - Required: eq=0, neq=1.
- Latency:
  - Setup: LATENCY=1, apply math vector at clk n.
  - Required: results appear at clk n+1 and hold until the inputs change.
  - Setup: rst.
  - Required: all math and dmx outputs are 0 on the next clk.
